// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC comb sequencer: FSM state encoding,
// a clog2 helper for index widths, and default channel geometry.
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMB = 2'd1,
        OUT  = 2'd2
    } cic_state_e;

    localparam int CIC_DEF_NCH    = 2;
    localparam int CIC_DEF_STAGES = 3;
    localparam int CIC_DEF_WIDTH  = 27;

    // Minimum width is 1 so single-entry indices still have a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cic_rr_arbiter.sv
// Combinational round-robin pick: first pending channel at or after rr_ptr,
// wrapping, reported both one-hot and as an index.
module cic_rr_arbiter
    import cic_pkg::*;
#(
    parameter  int NCH = CIC_DEF_NCH,
    localparam int CW  = clog2(NCH)
) (
    input  logic [NCH-1:0] pending,
    input  logic [CW-1:0]  rr_ptr,
    output logic [NCH-1:0] grant_onehot,
    output logic [CW-1:0]  grant_idx,
    output logic           grant_valid
);

    logic [CW:0]   sum;
    logic [CW-1:0] idx;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        sum          = '0;
        idx          = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, rr_ptr} + (CW+1)'(i);
            if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
            idx = sum[CW-1:0];
            if (!grant_valid && pending[idx]) begin
                grant_valid       = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cic_comb_sequencer.sv
// One comb subtractor time-shared across NCH CIC channels, round-robin.
// Define CIC_SEQ_SAT_EN to saturate the 16-bit output instead of wrapping.
module cic_comb_sequencer
    import cic_pkg::*;
#(
    parameter  int NCH       = CIC_DEF_NCH,
    parameter  int STAGES    = CIC_DEF_STAGES,
    parameter  int WIDTH     = CIC_DEF_WIDTH,
    parameter  int OUT_SHIFT = WIDTH - 17,
    localparam int CW        = clog2(NCH)
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*WIDTH-1:0]    integ_in,
    output logic signed [15:0]      x_out,
    output logic [CW-1:0]           out_chan,
    output logic                    out_tick,
    output logic [NCH-1:0]          overrun,
    output logic                    busy,
    output cic_state_e              dbg_state
);

    localparam int KW = clog2(STAGES);

    cic_state_e              state_q, state_d;
    logic [NCH-1:0]          pending_q, pending_d, overrun_set;
    logic [CW-1:0]           rr_q, chan_q;
    logic [KW-1:0]           k_q;
    logic signed [WIDTH-1:0] work_q;
    logic signed [WIDTH-1:0] hold_q [NCH];
    logic signed [WIDTH-1:0] del_q  [NCH][STAGES];

    logic [NCH-1:0]          grant_onehot;
    logic [CW-1:0]           grant_idx;
    logic                    grant_valid, grant_take;
    logic signed [WIDTH-1:0] shifted;
    logic signed [15:0]      out_val;

    cic_rr_arbiter #(.NCH(NCH)) u_arb (
        .pending      (pending_q),
        .rr_ptr       (rr_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid)
    );

    assign grant_take = (state_q == IDLE) && grant_valid;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

    // A request landing on the channel being granted re-arms it: set beats clear.
    always_comb begin
        pending_d   = pending_q;
        overrun_set = '0;
        if (grant_take) pending_d = pending_d & ~grant_onehot;
        overrun_set = req & pending_d;
        pending_d   = pending_d | req;
    end

    always_comb begin
        shifted = work_q >>> OUT_SHIFT;
`ifdef CIC_SEQ_SAT_EN
        if (shifted > WIDTH'(32767))       out_val = 16'sh7fff;
        else if (shifted < WIDTH'(-32768)) out_val = -16'sh8000;
        else                               out_val = shifted[15:0];
`else
        out_val = shifted[15:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = COMB;
            COMB:    if (k_q == KW'(STAGES-1)) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            pending_q <= '0;
            overrun   <= '0;
            rr_q      <= '0;
            chan_q    <= '0;
            k_q       <= '0;
            work_q    <= '0;
            x_out     <= '0;
            out_chan  <= '0;
            out_tick  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                hold_q[c] <= '0;
                for (int s = 0; s < STAGES; s++) del_q[c][s] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            overrun   <= overrun | overrun_set;
            out_tick  <= 1'b0;
            for (int c = 0; c < NCH; c++)
                if (req[c]) hold_q[c] <= integ_in[c*WIDTH +: WIDTH];

            case (state_q)
                IDLE: if (grant_valid) begin
                    work_q <= hold_q[grant_idx];
                    chan_q <= grant_idx;
                    k_q    <= '0;
                    rr_q   <= (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + CW'(1);
                end
                // Non-pipelined cascade: each stage consumes the previous stage's fresh result.
                COMB: begin
                    work_q             <= work_q - del_q[chan_q][k_q];
                    del_q[chan_q][k_q] <= work_q;
                    k_q                <= k_q + KW'(1);
                end
                OUT: begin
                    x_out    <= out_val;
                    out_chan <= chan_q;
                    out_tick <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comb_sequencer.sv
// Directed bench for cic_comb_sequencer (NCH=2, STAGES=3, WIDTH=27, OUT_SHIFT=10).
// Honours CIC_SEQ_SAT_EN for the overflow vector.
module tb_cic_comb_sequencer;
    import cic_pkg::*;

    logic               CLK = 1'b0;
    logic               RSTb = 1'b0;
    logic [1:0]         req = '0;
    logic [53:0]        integ_in = '0;
    logic signed [15:0] x_out;
    logic [0:0]         out_chan;
    logic               out_tick;
    logic [1:0]         overrun;
    logic               busy;
    cic_state_e         dbg_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    cic_comb_sequencer #(.NCH(2), .STAGES(3), .WIDTH(27), .OUT_SHIFT(10)) dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .req       (req),
        .integ_in  (integ_in),
        .x_out     (x_out),
        .out_chan  (out_chan),
        .out_tick  (out_tick),
        .overrun   (overrun),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RSTb = 1'b0;
        req  = '0;
        tick();
        tick();
        RSTb = 1'b1;
    endtask

    task automatic pulse(input logic [1:0] m, input logic signed [26:0] d0, input logic signed [26:0] d1);
        req      = m;
        integ_in = {d1, d0};
        tick();
        req      = '0;
    endtask

    task automatic wait_out(input int budget, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            tick();
            n++;
            if (out_tick === 1'b1) got = 1'b1;
        end
    endtask

    int n;
    bit got;
    int exp_step [4] = '{1024, -2048, 1024, 0};

    initial begin
        // Reset
        RSTb = 1'b0;
        tick();
        tick();
        check("rst_x_out", x_out, 0);
        check("rst_out_tick", out_tick, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_state", dbg_state, IDLE);
        RSTb = 1'b1;

        // Step on ch0: 2^20 repeated
        for (int i = 0; i < 4; i++) begin
            pulse(2'b01, 27'sd1048576, 27'sd0);
            wait_out(20, n, got);
            check("step_got", got, 1);
            check("step_latency", n + 1, 6);
            check("step_x_out", x_out, exp_step[i]);
            check("step_chan", out_chan, 0);
            tick();
            check("step_tick_width", out_tick, 0);
        end

        // Ties and round-robin
        do_reset();
        pulse(2'b11, 27'sd3072, -27'sd5120);
        wait_out(20, n, got);
        check("tie1_latency", n + 1, 6);
        check("tie1_first_chan", out_chan, 0);
        check("tie1_first_x", x_out, 3);
        wait_out(20, n, got);
        check("tie1_gap", n, 5);
        check("tie1_second_chan", out_chan, 1);
        check("tie1_second_x", x_out, -5);
        pulse(2'b01, 27'sd3072, 27'sd0);
        wait_out(20, n, got);
        check("solo_ch0_x", x_out, -6);
        check("solo_ch0_chan", out_chan, 0);
        pulse(2'b11, 27'sd3072, -27'sd5120);
        wait_out(20, n, got);
        check("tie2_latency", n + 1, 6);
        check("tie2_first_chan", out_chan, 1);
        check("tie2_first_x", x_out, 10);
        wait_out(20, n, got);
        check("tie2_gap", n, 5);
        check("tie2_second_chan", out_chan, 0);
        check("tie2_second_x", x_out, 3);
        check("tie_overrun", overrun, 0);

        // Overrun on ch1 while ch0 is in service
        do_reset();
        pulse(2'b01, 27'sd0, 27'sd0);
        pulse(2'b10, 27'sd0, 27'sd102400);
        tick();
        pulse(2'b10, 27'sd0, 27'sd7168);
        wait_out(20, n, got);
        check("ovr_ch0_wait", n, 2);
        check("ovr_ch0_chan", out_chan, 0);
        check("ovr_ch0_x", x_out, 0);
        check("ovr_flag", overrun, 2'b10);
        wait_out(20, n, got);
        check("ovr_ch1_gap", n, 5);
        check("ovr_ch1_chan", out_chan, 1);
        check("ovr_ch1_x", x_out, 7);
        wait_out(15, n, got);
        check("ovr_no_extra", got, 0);
        check("ovr_idle", busy, 0);
        check("ovr_sticky", overrun, 2'b10);

        // Output overflow
        do_reset();
        pulse(2'b01, 27'sd33554432, 27'sd0);
        wait_out(20, n, got);
        check("big_got", got, 1);
`ifdef CIC_SEQ_SAT_EN
        check("big_x_out", x_out, 32767);
`else
        check("big_x_out", x_out, -32768);
`endif

        // Reset during ch1 comb
        do_reset();
        pulse(2'b10, 27'sd0, 27'sd5120);
        wait_out(20, n, got);
        check("pre_x_out", x_out, 5);
        check("pre_chan", out_chan, 1);
        pulse(2'b10, 27'sd0, 27'sd5120);
        tick();
        tick();
        check("mid_busy", busy, 1);
        check("mid_state", dbg_state, COMB);
        RSTb = 1'b0;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tick", out_tick, 0);
        check("mid_rst_x_out", x_out, 0);
        RSTb = 1'b1;
        wait_out(12, n, got);
        check("mid_rst_dropped", got, 0);
        pulse(2'b10, 27'sd0, 27'sd5120);
        wait_out(20, n, got);
        check("post_latency", n + 1, 6);
        check("post_x_out", x_out, 5);
        check("post_chan", out_chan, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
